// File: rtl/tela_derrota_anim_pkg.sv
// Shared types and sprite data for the game-over screen renderer.
// Skull bitmap: one 11-bit word per row, bit c is column c, row 0 on top.
package tela_pkg;

    localparam int SPRITE_W = 11;
    localparam int SPRITE_H = 11;

    localparam logic [0:10][10:0] SPRITE_ROWS = '{
        11'h3FE, 11'h7FF, 11'h471, 11'h471, 11'h471, 11'h7FF,
        11'h7DF, 11'h7FF, 11'h3FE, 11'h154, 11'h154
    };

    typedef enum logic [1:0] {IDLE, FADE, SHOW} state_t;

    // Scales one colour channel by an 8-bit intensity (255 is just under unity).
    function automatic logic [7:0] fade_ch(input logic [7:0] c, input logic [7:0] k);
        logic [15:0] p;
        p = 16'(c) * 16'(k);
        return p[15:8];
    endfunction

endpackage

// File: rtl/tela_anim_fsm.sv
// Animation controller: fade-in ramp, then blink at a fixed frame period.
// All state moves on frame_tick only, except the enable on/off transitions.
module tela_anim_fsm
    import tela_pkg::*;
#(
    parameter logic [7:0] FADE_STEP    = 8'd64,
    parameter int         BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    output state_t     state,
    output logic [7:0] intensity,
    output logic       visible
);

    localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_FRAMES - 1);

    state_t        state_n;
    logic [7:0]    intensity_n;
    logic          visible_n;
    logic [CW-1:0] blink_cnt;
    logic [CW-1:0] blink_cnt_n;
    logic [8:0]    sum;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            intensity <= '0;
            visible   <= 1'b1;
            blink_cnt <= '0;
        end else begin
            state     <= state_n;
            intensity <= intensity_n;
            visible   <= visible_n;
            blink_cnt <= blink_cnt_n;
        end
    end

    always_comb begin
        state_n     = state;
        intensity_n = intensity;
        visible_n   = visible;
        blink_cnt_n = blink_cnt;
        sum         = {1'b0, intensity} + {1'b0, FADE_STEP};
        if (!enable) begin
            state_n     = IDLE;
            intensity_n = '0;
            visible_n   = 1'b1;
            blink_cnt_n = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    // A frame_tick coinciding with enable is deliberately dropped.
                    state_n     = FADE;
                    intensity_n = '0;
                end
                FADE: begin
                    if (frame_tick) begin
                        if (sum >= 9'd255) begin
                            state_n     = SHOW;
                            intensity_n = 8'hFF;
                            visible_n   = 1'b1;
                            blink_cnt_n = '0;
                        end else begin
                            intensity_n = sum[7:0];
                        end
                    end
                end
                SHOW: begin
                    if (frame_tick) begin
                        if (blink_cnt == CNT_LAST) begin
                            blink_cnt_n = '0;
                            visible_n   = ~visible;
                        end else begin
                            blink_cnt_n = blink_cnt + 1'b1;
                        end
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

endmodule

// File: rtl/tela_derrota_anim.sv
// Game-over screen renderer: scaled skull sprite with fade-in and blink.
// Two-stage pixel pipeline; animation state is sampled in the second stage.
module tela_derrota_anim
    import tela_pkg::*;
#(
    parameter int          SCALE        = 10,
    parameter int          X0           = 400,
    parameter int          Y0           = 200,
    parameter logic [7:0]  FADE_STEP    = 8'd64,
    parameter int          BLINK_FRAMES = 30,
    parameter logic [23:0] FG_COLOR     = 24'hFFFFFF,
    parameter logic [23:0] BG_COLOR     = 24'h000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] h_counter,
    input  logic [9:0] v_counter,
    input  logic       frame_tick,
    input  logic       enable,
    output logic [7:0] R,
    output logic [7:0] G,
    output logic [7:0] B,
    output logic       busy
);

    localparam logic [10:0] X_LO = 11'(X0);
    localparam logic [10:0] X_HI = 11'(X0 + SPRITE_W * SCALE);
    localparam logic [10:0] Y_LO = 11'(Y0);
    localparam logic [10:0] Y_HI = 11'(Y0 + SPRITE_H * SCALE);
    localparam logic [10:0] SC   = 11'(SCALE);

    state_t     state;
    logic [7:0] intensity;
    logic       visible;

    tela_anim_fsm #(
        .FADE_STEP    (FADE_STEP),
        .BLINK_FRAMES (BLINK_FRAMES)
    ) u_fsm (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .frame_tick (frame_tick),
        .state      (state),
        .intensity  (intensity),
        .visible    (visible)
    );

    assign busy = (state != IDLE);

    logic [10:0] hx, vy, dx, dy;
    logic        in_box_d;
    logic [3:0]  col_d, row_d;

    assign hx       = {1'b0, h_counter};
    assign vy       = {1'b0, v_counter};
    assign dx       = hx - X_LO;
    assign dy       = vy - Y_LO;
    assign in_box_d = (hx >= X_LO) && (hx < X_HI) && (vy >= Y_LO) && (vy < Y_HI);
    assign col_d    = in_box_d ? 4'(dx / SC) : 4'd0;
    assign row_d    = in_box_d ? 4'(dy / SC) : 4'd0;

    logic       in_box_q;
    logic [3:0] col_q, row_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_box_q <= 1'b0;
            col_q    <= '0;
            row_q    <= '0;
        end else begin
            in_box_q <= in_box_d;
            col_q    <= col_d;
            row_q    <= row_d;
        end
    end

    logic        sprite_bit;
    logic [23:0] rgb_d;

    assign sprite_bit = in_box_q && SPRITE_ROWS[row_q][col_q];

    always_comb begin
        rgb_d = '0;
        unique case (state)
            IDLE: rgb_d = '0;
            FADE: rgb_d = sprite_bit ? {fade_ch(FG_COLOR[23:16], intensity),
                                        fade_ch(FG_COLOR[15:8], intensity),
                                        fade_ch(FG_COLOR[7:0], intensity)}
                                     : BG_COLOR;
            SHOW: rgb_d = (sprite_bit && visible) ? FG_COLOR : BG_COLOR;
            default: rgb_d = '0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {R, G, B} <= '0;
        end else begin
            {R, G, B} <= rgb_d;
        end
    end

endmodule

// File: tb/tb_tela_derrota_anim.sv
// Self-checking bench for tela_derrota_anim: vector table plus scoreboard queue.
module tb_tela_derrota_anim;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] h_counter, v_counter;
    logic       frame_tick, enable;
    logic [7:0] R, G, B;
    logic       busy;

    always #5 clk = ~clk;

    tela_derrota_anim #(
        .SCALE        (10),
        .X0           (400),
        .Y0           (200),
        .FADE_STEP    (8'd64),
        .BLINK_FRAMES (2),
        .FG_COLOR     (24'hFFFFFF),
        .BG_COLOR     (24'h000000)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .h_counter  (h_counter),
        .v_counter  (v_counter),
        .frame_tick (frame_tick),
        .enable     (enable),
        .R          (R),
        .G          (G),
        .B          (B),
        .busy       (busy)
    );

    typedef struct {
        bit         en;
        int         ticks;
        int         h;
        int         v;
        logic [7:0] exp;
        string      nm;
    } vec_t;

    typedef struct {
        bit         chk;
        logic [7:0] exp;
        string      nm;
    } sb_t;

    int   checks   = 0;
    int   failures = 0;
    sb_t  sbq[$];
    vec_t tbl[$];

    task automatic check_val(input string nm, input logic [23:0] act, input logic [23:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // One pixel clock: retire the entry driven two clocks ago, then drive a new one.
    task automatic cyc(input int h, input int v, input bit chk, input logic [7:0] e,
                       input string nm, input bit tick, input bit en);
        sb_t s;
        @(negedge clk);
        if (sbq.size() >= 2) begin
            s = sbq.pop_front();
            if (s.chk) check_val(s.nm, {R, G, B}, {3{s.exp}});
        end
        h_counter  = 10'(h);
        v_counter  = 10'(v);
        frame_tick = tick;
        enable     = en;
        sbq.push_back('{chk, e, nm});
    endtask

    task automatic add(input bit en, input int ticks, input int h, input int v,
                       input logic [7:0] exp, input string nm);
        tbl.push_back('{en, ticks, h, v, exp, nm});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit cur_en;

        add(0, 0, 410, 200, 8'h00, "idle_a");
        add(0, 0, 440, 260, 8'h00, "idle_b");
        add(1, 1, 410, 200, 8'h3F, "fade64");
        add(1, 0, 400, 200, 8'h00, "fade64_bg");
        add(1, 0, 420, 290, 8'h3F, "fade64_c");
        add(1, 1, 410, 200, 8'h7F, "fade128");
        add(1, 1, 440, 260, 8'hBF, "fade192");
        add(1, 1, 440, 260, 8'hFF, "show_a");
        add(1, 0, 450, 260, 8'h00, "show_b");
        add(1, 0, 420, 290, 8'hFF, "show_c");
        add(1, 0, 509, 210, 8'hFF, "edge_right_in");
        add(1, 0, 510, 210, 8'h00, "edge_right_out");
        add(1, 0, 399, 210, 8'h00, "edge_left_out");
        add(1, 0, 405, 309, 8'h00, "edge_row10_c0");
        add(1, 0, 420, 309, 8'hFF, "edge_row10_c2");
        add(1, 0, 420, 310, 8'h00, "edge_bottom_out");
        add(1, 0, 600, 400, 8'h00, "bg_far");
        add(1, 1, 410, 200, 8'hFF, "blink1");
        add(1, 1, 410, 200, 8'h00, "blink2");
        add(1, 0, 440, 260, 8'h00, "blink2_b");
        add(1, 1, 410, 200, 8'h00, "blink3");
        add(1, 1, 410, 200, 8'hFF, "blink4");

        reset = 1'b1; enable = 1'b0; frame_tick = 1'b0;
        h_counter = '0; v_counter = '0;
        #1;
        check_val("reset_rgb", {R, G, B}, 24'h0);
        check_val("reset_busy", {23'h0, busy}, 24'h0);
        repeat (2) @(negedge clk);
        reset = 1'b0;

        cur_en = 1'b0;
        foreach (tbl[i]) begin
            if (tbl[i].ticks > 0 || tbl[i].en != cur_en) begin
                repeat (3) cyc(0, 0, 0, 8'h00, "", 0, tbl[i].en);
                check_val({"busy_", tbl[i].nm}, {23'h0, busy}, {23'h0, tbl[i].en});
                for (int t = 0; t < tbl[i].ticks; t++) begin
                    cyc(0, 0, 0, 8'h00, "", 1, tbl[i].en);
                    cyc(0, 0, 0, 8'h00, "", 0, tbl[i].en);
                end
                repeat (2) cyc(0, 0, 0, 8'h00, "", 0, tbl[i].en);
            end
            cur_en = tbl[i].en;
            cyc(tbl[i].h, tbl[i].v, 1, tbl[i].exp, tbl[i].nm, 0, tbl[i].en);
        end

        // Enable drop while visible: pixels driven after the drop must be black.
        cyc(410, 200, 1, 8'hFF, "drop_pre0", 0, 1);
        cyc(410, 200, 1, 8'hFF, "drop_pre1", 0, 1);
        cyc(410, 200, 1, 8'h00, "drop_at", 0, 0);
        cyc(410, 200, 1, 8'h00, "drop_next", 0, 0);
        check_val("drop_busy", {23'h0, busy}, 24'h0);

        // Re-enable restarts the fade from zero.
        repeat (3) cyc(0, 0, 0, 8'h00, "", 0, 1);
        check_val("reen_busy", {23'h0, busy}, 24'h1);
        cyc(0, 0, 0, 8'h00, "", 1, 1);
        repeat (2) cyc(0, 0, 0, 8'h00, "", 0, 1);
        repeat (4) cyc(410, 200, 1, 8'h3F, "reen_fade", 0, 1);

        // Asynchronous reset with no clock edge.
        @(negedge clk);
        check_val("pre_reset_rgb", {R, G, B}, 24'h3F3F3F);
        #2 reset = 1'b1;
        #1;
        check_val("async_reset_rgb", {R, G, B}, 24'h0);
        check_val("async_reset_busy", {23'h0, busy}, 24'h0);
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
        repeat (3) cyc(410, 200, 1, 8'h00, "post_reset_off", 0, 0);
        repeat (2) cyc(0, 0, 0, 8'h00, "", 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
